game_state_mem: RTL and testbench

GAME_STATE_MEM -- requirements
Module: game_state_mem

---
 rtl/color_bounce_pkg.sv | 31 +++
 rtl/plat_shift_reg.sv | 59 +++++
 rtl/game_state_mem.sv | 148 ++++++++++++++
 tb/tb_game_state_mem.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/color_bounce_pkg.sv
// Shared types and default constants for the colour-bounce game state memory.
package color_bounce_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StScroll,
        StClear
    } game_state_e;

    localparam int unsigned DEFAULT_NUM_PLATS = 4;
    localparam int unsigned DEFAULT_POS_W     = 7;
    localparam int unsigned DEFAULT_COLOR_W   = 3;
    localparam int unsigned DEFAULT_BALL_W    = 8;
    localparam int unsigned DEFAULT_SCORE_W   = 12;

    // Slot 0 sits in the LSBs.
    localparam logic [27:0] DEFAULT_PLAT_POS   = 28'b0011110_0111100_1011010_1100100;
    localparam logic [11:0] DEFAULT_PLAT_COLOR = 12'b001_110_111_101;

    // Width of the packed platform position vector.
    function automatic int unsigned plat_pos_width(int unsigned num_plats, int unsigned pos_w);
        return num_plats * pos_w;
    endfunction

    // Width of the packed platform colour vector.
    function automatic int unsigned plat_color_width(int unsigned num_plats,
                                                     int unsigned color_w);
        return num_plats * color_w;
    endfunction

endpackage

// File: rtl/plat_shift_reg.sv
// Platform slot array: colour load, shift-in at slot 0, and clear-to-default.
module plat_shift_reg
    import color_bounce_pkg::*;
#(
    parameter int unsigned NUM_PLATS = DEFAULT_NUM_PLATS,
    parameter int unsigned POS_W     = DEFAULT_POS_W,
    parameter int unsigned COLOR_W   = DEFAULT_COLOR_W,
    parameter logic [plat_pos_width(NUM_PLATS, POS_W)-1:0]     DEF_PLAT_POS   = DEFAULT_PLAT_POS,
    parameter logic [plat_color_width(NUM_PLATS, COLOR_W)-1:0] DEF_PLAT_COLOR = DEFAULT_PLAT_COLOR
) (
    input  logic                                             clk_i,
    input  logic                                             rst_ni,
    input  logic                                             clear_i,
    input  logic                                             shift_i,
    input  logic [POS_W-1:0]                                 shift_pos_i,
    input  logic [COLOR_W-1:0]                               shift_color_i,
    input  logic                                             load_i,
    input  logic [plat_color_width(NUM_PLATS, COLOR_W)-1:0]  color_i,
    output logic [plat_pos_width(NUM_PLATS, POS_W)-1:0]      pos_o,
    output logic [plat_color_width(NUM_PLATS, COLOR_W)-1:0]  color_o
);

    localparam int unsigned PW = plat_pos_width(NUM_PLATS, POS_W);
    localparam int unsigned CW = plat_color_width(NUM_PLATS, COLOR_W);

    logic [PW-1:0] pos_q, pos_d;
    logic [CW-1:0] color_q, color_d;

    // Next slot contents; clear beats shift beats load.
    always_comb begin
        pos_d   = pos_q;
        color_d = color_q;
        if (clear_i) begin
            pos_d   = DEF_PLAT_POS;
            color_d = DEF_PLAT_COLOR;
        end else if (shift_i) begin
            // Every slot moves up one; the top slot falls off.
            pos_d   = {pos_q[PW-POS_W-1:0], shift_pos_i};
            color_d = {color_q[CW-COLOR_W-1:0], shift_color_i};
        end else if (load_i) begin
            color_d = color_i;
        end
    end

    // Slot storage with asynchronous reset to the default layout.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pos_q   <= DEF_PLAT_POS;
            color_q <= DEF_PLAT_COLOR;
        end else begin
            pos_q   <= pos_d;
            color_q <= color_d;
        end
    end

    assign pos_o   = pos_q;
    assign color_o = color_q;

endmodule

// File: rtl/game_state_mem.sv
// Game state memory: ball, platform layout, score and high score behind a
// three-state controller (idle / scroll / clear).
module game_state_mem
    import color_bounce_pkg::*;
#(
    parameter int unsigned NUM_PLATS = DEFAULT_NUM_PLATS,
    parameter int unsigned POS_W     = DEFAULT_POS_W,
    parameter int unsigned COLOR_W   = DEFAULT_COLOR_W,
    parameter int unsigned BALL_W    = DEFAULT_BALL_W,
    parameter int unsigned SCORE_W   = DEFAULT_SCORE_W,
    parameter logic [NUM_PLATS*POS_W-1:0]   DEF_PLAT_POS   = DEFAULT_PLAT_POS,
    parameter logic [NUM_PLATS*COLOR_W-1:0] DEF_PLAT_COLOR = DEFAULT_PLAT_COLOR
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           commit_valid,
    output logic                           commit_ready,
    input  logic [BALL_W-1:0]              ball_in,
    input  logic [COLOR_W-1:0]             color_ball_in,
    input  logic [NUM_PLATS*COLOR_W-1:0]   color_plats_in,
    input  logic                           score_inc,
    input  logic                           scroll_req,
    input  logic [POS_W-1:0]               new_plat_pos,
    input  logic [COLOR_W-1:0]             new_plat_color,
    input  logic                           game_over,
    output logic [BALL_W-1:0]              prev_ball_out,
    output logic [BALL_W-1:0]              curr_ball_out,
    output logic [COLOR_W-1:0]             color_ball_out,
    output logic [NUM_PLATS*COLOR_W-1:0]   color_plats_out,
    output logic [NUM_PLATS*POS_W-1:0]     position_plats_out,
    output logic [SCORE_W-1:0]             score_out,
    output logic [SCORE_W-1:0]             high_score_out,
    output logic                           busy
);

    game_state_e        state_q, state_d;
    logic [BALL_W-1:0]  prev_ball_q, prev_ball_d;
    logic [BALL_W-1:0]  curr_ball_q, curr_ball_d;
    logic [COLOR_W-1:0] color_ball_q, color_ball_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [SCORE_W-1:0] high_score_q, high_score_d;
    logic [POS_W-1:0]   scroll_pos_q, scroll_pos_d;
    logic [COLOR_W-1:0] scroll_color_q, scroll_color_d;

    logic plat_clear, plat_shift, plat_load;

    // Next-state and datapath updates; idle arbitrates game_over > scroll > commit.
    always_comb begin
        state_d        = state_q;
        prev_ball_d    = prev_ball_q;
        curr_ball_d    = curr_ball_q;
        color_ball_d   = color_ball_q;
        score_d        = score_q;
        high_score_d   = high_score_q;
        scroll_pos_d   = scroll_pos_q;
        scroll_color_d = scroll_color_q;
        plat_clear     = 1'b0;
        plat_shift     = 1'b0;
        plat_load      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (game_over) begin
                    if (score_q > high_score_q) begin
                        high_score_d = score_q;
                    end
                    state_d = StClear;
                end else if (scroll_req) begin
                    scroll_pos_d   = new_plat_pos;
                    scroll_color_d = new_plat_color;
                    state_d        = StScroll;
                end else if (commit_valid) begin
                    prev_ball_d  = curr_ball_q;
                    curr_ball_d  = ball_in;
                    color_ball_d = color_ball_in;
                    plat_load    = 1'b1;
                    // Score saturates rather than wrapping.
                    if (score_inc && (score_q != {SCORE_W{1'b1}})) begin
                        score_d = score_q + 1'b1;
                    end
                end
            end
            StScroll: begin
                plat_shift = 1'b1;
                state_d    = StIdle;
            end
            StClear: begin
                prev_ball_d  = '0;
                curr_ball_d  = '0;
                color_ball_d = '1;
                score_d      = '0;
                plat_clear   = 1'b1;
                state_d      = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Controller and ball/score registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= StIdle;
            prev_ball_q    <= '0;
            curr_ball_q    <= '0;
            color_ball_q   <= '1;
            score_q        <= '0;
            high_score_q   <= '0;
            scroll_pos_q   <= '0;
            scroll_color_q <= '0;
        end else begin
            state_q        <= state_d;
            prev_ball_q    <= prev_ball_d;
            curr_ball_q    <= curr_ball_d;
            color_ball_q   <= color_ball_d;
            score_q        <= score_d;
            high_score_q   <= high_score_d;
            scroll_pos_q   <= scroll_pos_d;
            scroll_color_q <= scroll_color_d;
        end
    end

    plat_shift_reg #(
        .NUM_PLATS      (NUM_PLATS),
        .POS_W          (POS_W),
        .COLOR_W        (COLOR_W),
        .DEF_PLAT_POS   (DEF_PLAT_POS),
        .DEF_PLAT_COLOR (DEF_PLAT_COLOR)
    ) u_plats (
        .clk_i         (clk),
        .rst_ni        (reset),
        .clear_i       (plat_clear),
        .shift_i       (plat_shift),
        .shift_pos_i   (scroll_pos_q),
        .shift_color_i (scroll_color_q),
        .load_i        (plat_load),
        .color_i       (color_plats_in),
        .pos_o         (position_plats_out),
        .color_o       (color_plats_out)
    );

    assign commit_ready   = (state_q == StIdle);
    assign busy           = ~commit_ready;
    assign prev_ball_out  = prev_ball_q;
    assign curr_ball_out  = curr_ball_q;
    assign color_ball_out = color_ball_q;
    assign score_out      = score_q;
    assign high_score_out = high_score_q;

endmodule

// File: tb/tb_game_state_mem.sv
// Self-checking bench for game_state_mem against a slot-array reference model.
module tb_game_state_mem;

    localparam int N  = 4;
    localparam int PW = 7;
    localparam int CW = 3;
    localparam int BW = 8;
    localparam int SW = 12;
    localparam int SCORE_MAX = 4095;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            commit_valid = 1'b0;
    logic            commit_ready;
    logic [BW-1:0]   ball_in = '0;
    logic [CW-1:0]   color_ball_in = '0;
    logic [N*CW-1:0] color_plats_in = '0;
    logic            score_inc = 1'b0;
    logic            scroll_req = 1'b0;
    logic [PW-1:0]   new_plat_pos = '0;
    logic [CW-1:0]   new_plat_color = '0;
    logic            game_over = 1'b0;
    logic [BW-1:0]   prev_ball_out, curr_ball_out;
    logic [CW-1:0]   color_ball_out;
    logic [N*CW-1:0] color_plats_out;
    logic [N*PW-1:0] position_plats_out;
    logic [SW-1:0]   score_out, high_score_out;
    logic            busy;

    always #5 clk = ~clk;

    game_state_mem dut (
        .clk                (clk),
        .reset              (reset),
        .commit_valid       (commit_valid),
        .commit_ready       (commit_ready),
        .ball_in            (ball_in),
        .color_ball_in      (color_ball_in),
        .color_plats_in     (color_plats_in),
        .score_inc          (score_inc),
        .scroll_req         (scroll_req),
        .new_plat_pos       (new_plat_pos),
        .new_plat_color     (new_plat_color),
        .game_over          (game_over),
        .prev_ball_out      (prev_ball_out),
        .curr_ball_out      (curr_ball_out),
        .color_ball_out     (color_ball_out),
        .color_plats_out    (color_plats_out),
        .position_plats_out (position_plats_out),
        .score_out          (score_out),
        .high_score_out     (high_score_out),
        .busy               (busy)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: plain integers, slot arrays, and a pending-operation flag.
    int m_prev, m_curr, m_cb, m_score, m_hi, m_lpos, m_lcol;
    int m_pos[N];
    int m_col[N];
    bit m_scroll_pending, m_clear_pending;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_defaults();
        m_prev = 0; m_curr = 0; m_cb = 7; m_score = 0;
        m_pos[0] = 'h64; m_pos[1] = 'h5A; m_pos[2] = 'h3C; m_pos[3] = 'h1E;
        m_col[0] = 5;    m_col[1] = 7;    m_col[2] = 6;    m_col[3] = 1;
    endtask

    task automatic model_reset();
        model_defaults();
        m_hi = 0; m_lpos = 0; m_lcol = 0;
        m_scroll_pending = 0; m_clear_pending = 0;
    endtask

    // One rising edge of the model, using the inputs currently applied.
    task automatic model_update();
        if (m_scroll_pending) begin
            for (int i = N - 1; i > 0; i--) begin
                m_pos[i] = m_pos[i-1];
                m_col[i] = m_col[i-1];
            end
            m_pos[0] = m_lpos;
            m_col[0] = m_lcol;
            m_scroll_pending = 0;
        end else if (m_clear_pending) begin
            model_defaults();
            m_clear_pending = 0;
        end else if (game_over) begin
            if (m_score > m_hi) m_hi = m_score;
            m_clear_pending = 1;
        end else if (scroll_req) begin
            m_lpos = int'(new_plat_pos);
            m_lcol = int'(new_plat_color);
            m_scroll_pending = 1;
        end else if (commit_valid) begin
            m_prev = m_curr;
            m_curr = int'(ball_in);
            m_cb = int'(color_ball_in);
            for (int i = 0; i < N; i++) m_col[i] = int'(color_plats_in[i*CW +: CW]);
            if (score_inc && m_score < SCORE_MAX) m_score = m_score + 1;
        end
    endtask

    function automatic logic [63:0] exp_pos();
        logic [63:0] r = '0;
        for (int i = 0; i < N; i++) r |= 64'(m_pos[i]) << (i * PW);
        return r;
    endfunction

    function automatic logic [63:0] exp_col();
        logic [63:0] r = '0;
        for (int i = 0; i < N; i++) r |= 64'(m_col[i]) << (i * CW);
        return r;
    endfunction

    task automatic check_all();
        bit idle = !(m_scroll_pending || m_clear_pending);
        check_val("prev_ball", 64'(prev_ball_out), 64'(m_prev));
        check_val("curr_ball", 64'(curr_ball_out), 64'(m_curr));
        check_val("color_ball", 64'(color_ball_out), 64'(m_cb));
        check_val("plat_pos", 64'(position_plats_out), exp_pos());
        check_val("plat_color", 64'(color_plats_out), exp_col());
        check_val("score", 64'(score_out), 64'(m_score));
        check_val("high_score", 64'(high_score_out), 64'(m_hi));
        check_val("commit_ready", 64'(commit_ready), 64'(idle));
        check_val("busy", 64'(busy), 64'(!idle));
    endtask

    task automatic set_in(input bit gov, input bit scr, input bit cv, input int ball,
                          input int cb, input int cplats, input bit inc, input int npos,
                          input int ncol);
        game_over      = gov;
        scroll_req     = scr;
        commit_valid   = cv;
        ball_in        = BW'(ball);
        color_ball_in  = CW'(cb);
        color_plats_in = (N*CW)'(cplats);
        score_inc      = inc;
        new_plat_pos   = PW'(npos);
        new_plat_color = CW'(ncol);
    endtask

    task automatic idle_in();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Advance one clock, update the model, then sample the DUT 1 ns later.
    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        check_all();
    endtask

    task automatic commit(input int ball, input bit inc);
        set_in(0, 0, 1, ball, 3, 'h3BD, inc, 0, 0);
        step();
    endtask

    initial begin
        // Reset, released away from a clock edge.
        idle_in();
        model_reset();
        #12;
        check_all();
        reset = 1'b1;
        #1;
        check_val("rst_pos", 64'(position_plats_out), 64'h3CF2D64);
        check_val("rst_color", 64'(color_plats_out), 64'h3BD);
        check_val("rst_cball", 64'(color_ball_out), 64'h7);
        check_val("rst_score", 64'(score_out), 64'h0);
        check_val("rst_ready", 64'(commit_ready), 64'h1);

        // Two scoring commits.
        commit('h12, 1);
        commit('h34, 1);
        idle_in();
        check_val("c2_curr", 64'(curr_ball_out), 64'h34);
        check_val("c2_prev", 64'(prev_ball_out), 64'h12);
        check_val("c2_score", 64'(score_out), 64'h2);

        // Scroll in a new slot 0.
        set_in(0, 1, 0, 0, 0, 0, 0, 'h05, 2);
        step();
        idle_in();
        check_val("scr_busy_ready", 64'(commit_ready), 64'h0);
        step();
        check_val("scr_done_ready", 64'(commit_ready), 64'h1);
        check_val("scr_slot0_pos", 64'(position_plats_out[6:0]), 64'h05);
        check_val("scr_slot0_col", 64'(color_plats_out[2:0]), 64'h2);
        check_val("scr_slot1_pos", 64'(position_plats_out[13:7]), 64'h64);
        check_val("scr_slot1_col", 64'(color_plats_out[5:3]), 64'h5);
        check_val("scr_slot3_pos", 64'(position_plats_out[27:21]), 64'h3C);

        // Reach score 9 / high 4, then collide game_over, scroll and commit.
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0); step(); idle_in(); step();
        for (int i = 0; i < 4; i++) commit(i + 1, 1);
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0); step(); idle_in(); step();
        for (int i = 0; i < 9; i++) commit(i + 'h40, 1);
        check_val("go_pre_score", 64'(score_out), 64'h9);
        check_val("go_pre_high", 64'(high_score_out), 64'h4);
        set_in(1, 1, 1, 'h77, 2, 'h123, 1, 'h11, 4);
        step();
        idle_in();
        step();
        check_val("go_high", 64'(high_score_out), 64'h9);
        check_val("go_score", 64'(score_out), 64'h0);
        check_val("go_pos", 64'(position_plats_out), 64'h3CF2D64);
        check_val("go_color", 64'(color_plats_out), 64'h3BD);
        check_val("go_curr", 64'(curr_ball_out), 64'h0);

        // Drive score to saturation, then one more scoring commit.
        for (int i = 0; i < SCORE_MAX; i++) commit(i & 'hFF, 1);
        check_val("sat_pre", 64'(score_out), 64'hFFF);
        commit('hAB, 1);
        idle_in();
        check_val("sat_hold", 64'(score_out), 64'hFFF);
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0); step(); idle_in(); step();

        // Reset pulsed while a scroll is pending.
        set_in(0, 1, 0, 0, 0, 0, 0, 'h09, 3);
        step();
        idle_in();
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_all();
        check_val("rs_high", 64'(high_score_out), 64'h0);
        check_val("rs_pos", 64'(position_plats_out), 64'h3CF2D64);
        #1;
        reset = 1'b1;
        step();
        check_val("rs_idle", 64'(commit_ready), 64'h1);

        // Randomised traffic against the model.
        for (int c = 0; c < 600; c++) begin
            set_in($urandom_range(0, 99) < 4, $urandom_range(0, 99) < 15,
                   $urandom_range(0, 99) < 60, int'($urandom_range(0, 255)),
                   int'($urandom_range(0, 7)), int'($urandom_range(0, 4095)),
                   $urandom_range(0, 1) == 1, int'($urandom_range(0, 127)),
                   int'($urandom_range(0, 7)));
            step();
        end
        idle_in();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
